// File: rtl/load_store_unit_pkg.sv
// Shared control types for the memory stage: instruction classes, memory sub-types,
// LSU state encoding and access-size masks.
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        ALU,
        LOAD,
        STORE,
        BRANCH,
        JUMP,
        SYSTEM
    } InstructionTypes;

    typedef enum logic [3:0] {
        SUB_NONE,
        LOAD_BYTE,
        LOAD_HALF,
        LOAD_WORD,
        ULOAD_BYTE,
        ULOAD_HALF,
        STORE_BYTE,
        STORE_HALF,
        STORE_WORD
    } InstructionSubTypes;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        RESP
    } LsuState;

    localparam logic [3:0] SIZE_MASK_BYTE = 4'h1;
    localparam logic [3:0] SIZE_MASK_HALF = 4'h3;
    localparam logic [3:0] SIZE_MASK_WORD = 4'hF;

    // Anything that is not a byte or halfword sub-type behaves as a full word.
    function automatic logic [3:0] size_mask(input InstructionSubTypes sub);
        case (sub)
            LOAD_BYTE, ULOAD_BYTE, STORE_BYTE: size_mask = SIZE_MASK_BYTE;
            LOAD_HALF, ULOAD_HALF, STORE_HALF: size_mask = SIZE_MASK_HALF;
            default:                           size_mask = SIZE_MASK_WORD;
        endcase
    endfunction

    function automatic logic is_unsigned(input InstructionSubTypes sub);
        is_unsigned = (sub == ULOAD_BYTE) || (sub == ULOAD_HALF);
    endfunction

    function automatic logic is_crossing(input logic [1:0] off, input logic [3:0] mask);
        logic [7:0] wide;
        wide        = {4'b0000, mask} << off;
        is_crossing = |wide[7:4];
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-RAM signals of the load/store unit.
// slave = the LSU itself, master = the pipeline/RAM environment driving it.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    import load_store_unit_pkg::*;

    logic                  iValid;
    InstructionTypes       iInstructionType;
    InstructionSubTypes    iMemoryInstructionType;
    logic [ADDR_WIDTH-1:0] iAddress;
    logic [31:0]           iWriteData;
    logic                  oBusy;
    logic                  oRespValid;
    logic [31:0]           oLoadData;
    logic                  oMisaligned;
    logic                  oMemEn;
    logic                  oMemWriteEn;
    logic [ADDR_WIDTH-1:0] oMemAddress;
    logic [3:0]            oMemByteEn;
    logic [31:0]           oMemWriteData;
    logic [31:0]           iMemReadData;

    modport slave (
        input  iValid, iInstructionType, iMemoryInstructionType, iAddress, iWriteData, iMemReadData,
        output oBusy, oRespValid, oLoadData, oMisaligned,
        output oMemEn, oMemWriteEn, oMemAddress, oMemByteEn, oMemWriteData
    );

    modport master (
        output iValid, iInstructionType, iMemoryInstructionType, iAddress, iWriteData, iMemReadData,
        input  oBusy, oRespValid, oLoadData, oMisaligned,
        input  oMemEn, oMemWriteEn, oMemAddress, oMemByteEn, oMemWriteData
    );

endinterface

// File: rtl/load_store_unit_lane_align.sv
// Combinational byte-lane steering: store data/enables spread over two words,
// load data merged from two words, shifted down and sign/zero-extended.
module lsu_lane_align (
    input  logic [1:0]  off_i,
    input  logic [3:0]  mask_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rd_word_i,
    input  logic [31:0] lo_word_i,
    output logic [63:0] wdata64_o,
    output logic [7:0]  wide_o,
    output logic        crossing_o,
    output logic [31:0] load_data_o
);
    logic [63:0] merged;
    logic [31:0] aligned;

    always_comb begin
        wide_o     = {4'b0000, mask_i} << off_i;
        crossing_o = |wide_o[7:4];
        wdata64_o  = {32'h0, wdata_i} << {off_i, 3'b000};

        // A non-crossing access only ever reads one word, which then serves as the low word.
        merged  = crossing_o ? {rd_word_i, lo_word_i} : {32'h0, rd_word_i};
        aligned = 32'(merged >> {off_i, 3'b000});

        case (mask_i)
            4'h1:    load_data_o = unsigned_i ? {24'h0, aligned[7:0]}
                                              : {{24{aligned[7]}}, aligned[7:0]};
            4'h3:    load_data_o = unsigned_i ? {16'h0, aligned[15:0]}
                                              : {{16{aligned[15]}}, aligned[15:0]};
            default: load_data_o = aligned;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, aligned RAM word accesses, split of word-crossing
// accesses into LO/HI cycles. Optional MISALIGN_TRAP_EN traps crossing requests instead.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic              iClk,
    input  logic              iRst,
    load_store_unit_if.slave  lsu
);
    LsuState               state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] lo_word_q;
    logic [3:0]            mask_q;
    logic                  store_q;
    logic                  unsigned_q;

    logic                  accept;
    logic [63:0]           wdata64;
    logic [7:0]            wide;
    logic                  crossing;
    logic [31:0]           load_data;
    logic [ADDR_WIDTH-1:0] word_addr;

    assign accept    = (state_q == IDLE) && lsu.iValid &&
                       ((lsu.iInstructionType == LOAD) || (lsu.iInstructionType == STORE));
    assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

    lsu_lane_align u_align (
        .off_i       (addr_q[1:0]),
        .mask_i      (mask_q),
        .unsigned_i  (unsigned_q),
        .wdata_i     (wdata_q),
        .rd_word_i   (lsu.iMemReadData),
        .lo_word_i   (lo_word_q),
        .wdata64_o   (wdata64),
        .wide_o      (wide),
        .crossing_o  (crossing),
        .load_data_o (load_data)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            lo_word_q  <= '0;
            mask_q     <= '0;
            store_q    <= 1'b0;
            unsigned_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q     <= lsu.iAddress;
                wdata_q    <= lsu.iWriteData;
                mask_q     <= size_mask(lsu.iMemoryInstructionType);
                store_q    <= (lsu.iInstructionType == STORE);
                unsigned_q <= is_unsigned(lsu.iMemoryInstructionType);
            end
            // During HI the RAM returns the word read in LO.
            if (state_q == HI) begin
                lo_word_q <= lsu.iMemReadData;
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        lsu.oBusy         = (state_q != IDLE);
        lsu.oRespValid    = 1'b0;
        lsu.oLoadData     = '0;
        lsu.oMisaligned   = 1'b0;
        lsu.oMemEn        = 1'b0;
        lsu.oMemWriteEn   = 1'b0;
        lsu.oMemAddress   = '0;
        lsu.oMemByteEn    = '0;
        lsu.oMemWriteData = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef MISALIGN_TRAP_EN
                    state_d = is_crossing(lsu.iAddress[1:0], size_mask(lsu.iMemoryInstructionType))
                              ? RESP : LO;
`else
                    state_d = LO;
`endif
                end
            end
            LO: begin
                lsu.oMemEn        = 1'b1;
                lsu.oMemWriteEn   = store_q;
                lsu.oMemAddress   = word_addr;
                lsu.oMemByteEn    = store_q ? wide[3:0] : 4'h0;
                lsu.oMemWriteData = wdata64[31:0];
                state_d           = crossing ? HI : RESP;
            end
            HI: begin
                lsu.oMemEn        = 1'b1;
                lsu.oMemWriteEn   = store_q;
                lsu.oMemAddress   = word_addr + ADDR_WIDTH'(4);
                lsu.oMemByteEn    = store_q ? wide[7:4] : 4'h0;
                lsu.oMemWriteData = wdata64[63:32];
                state_d           = RESP;
            end
            RESP: begin
                lsu.oRespValid = 1'b1;
`ifdef MISALIGN_TRAP_EN
                lsu.oMisaligned = crossing;
                lsu.oLoadData   = (store_q || crossing) ? 32'h0 : load_data;
`else
                lsu.oLoadData   = store_q ? 32'h0 : load_data;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-lane RAM model; honours MISALIGN_TRAP_EN.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .iClk (clk),
        .iRst (rst),
        .lsu  (bus)
    );

    logic [31:0] mem [0:15];
    logic [31:0] ram_rd = 32'h0;
    assign bus.iMemReadData = ram_rd;

    always @(posedge clk) begin
        if (bus.oMemEn) begin
            ram_rd <= mem[bus.oMemAddress[5:2]];
            if (bus.oMemWriteEn) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.oMemByteEn[b]) mem[bus.oMemAddress[5:2]][8*b +: 8] <= bus.oMemWriteData[8*b +: 8];
                end
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    int          nacc;
    int          resp_cyc;
    logic [31:0] acc_addr [2];
    logic [3:0]  acc_be   [2];
    logic [31:0] acc_dat  [2];
    logic        acc_we   [2];
    logic [31:0] resp_ld;
    logic        resp_mis;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Issues one request and records RAM accesses and the response, cycle 1 = N+1.
    task automatic issue(input InstructionTypes t, input InstructionSubTypes s,
                         input logic [31:0] a, input logic [31:0] wd);
        nacc     = 0;
        resp_cyc = 0;
        resp_ld  = 32'h0;
        resp_mis = 1'b0;
        @(negedge clk);
        bus.iValid                 = 1'b1;
        bus.iInstructionType       = t;
        bus.iMemoryInstructionType = s;
        bus.iAddress               = a;
        bus.iWriteData             = wd;
        for (int c = 1; c <= 6 && resp_cyc == 0; c++) begin
            @(negedge clk);
            bus.iValid = 1'b0;
            if (bus.oMemEn) begin
                if (nacc < 2) begin
                    acc_addr[nacc] = bus.oMemAddress;
                    acc_be[nacc]   = bus.oMemByteEn;
                    acc_dat[nacc]  = bus.oMemWriteData;
                    acc_we[nacc]   = bus.oMemWriteEn;
                end
                nacc++;
            end
            if (bus.oRespValid) begin
                resp_cyc = c;
                resp_ld  = bus.oLoadData;
                resp_mis = bus.oMisaligned;
            end
        end
        if (resp_cyc == 0) check("resp_timeout", 32'(resp_cyc), 32'd1);
    endtask

    task automatic load_expect(input string tag, input InstructionSubTypes s,
                               input logic [31:0] a, input logic [31:0] exp, input int lat);
        issue(LOAD, s, a, 32'h0);
        check({tag, "_data"}, resp_ld, exp);
        check({tag, "_lat"}, 32'(resp_cyc), 32'(lat));
    endtask

    initial begin
        bus.iValid                 = 1'b0;
        bus.iInstructionType       = ALU;
        bus.iMemoryInstructionType = SUB_NONE;
        bus.iAddress               = 32'h0;
        bus.iWriteData             = 32'h0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.oBusy), 32'd0);
        check("rst_resp", 32'(bus.oRespValid), 32'd0);
        check("rst_memen", 32'(bus.oMemEn), 32'd0);
        check("rst_addr", bus.oMemAddress, 32'h0);
        check("rst_ld", bus.oLoadData, 32'h0);
        rst = 1'b0;

        issue(STORE, STORE_WORD, 32'h0001_0004, 32'hDEAD_BEEF);
        check("sw_nacc", 32'(nacc), 32'd1);
        check("sw_addr", acc_addr[0], 32'h0001_0004);
        check("sw_be", 32'(acc_be[0]), 32'hF);
        check("sw_we", 32'(acc_we[0]), 32'd1);
        check("sw_dat", acc_dat[0], 32'hDEAD_BEEF);
        check("sw_lat", 32'(resp_cyc), 32'd2);
        check("sw_ld", resp_ld, 32'h0);

        issue(STORE, STORE_BYTE, 32'h0001_0002, 32'h0000_00AB);
        check("sb_be", 32'(acc_be[0]), 32'h4);
        check("sb_dat", acc_dat[0], 32'h00AB_0000);
        check("sb_addr", acc_addr[0], 32'h0001_0000);

        issue(LOAD, ULOAD_BYTE, 32'h0001_0002, 32'h0);
        check("lbu_data", resp_ld, 32'h0000_00AB);
        check("lbu_be", 32'(acc_be[0]), 32'h0);
        check("lbu_we", 32'(acc_we[0]), 32'd0);
        load_expect("lb", LOAD_BYTE, 32'h0001_0002, 32'hFFFF_FFAB, 2);
        load_expect("lw_al", LOAD_WORD, 32'h0001_0004, 32'hDEAD_BEEF, 2);

`ifdef MISALIGN_TRAP_EN
        issue(LOAD, LOAD_WORD, 32'h0001_0001, 32'h0);
        check("trap_nacc", 32'(nacc), 32'd0);
        check("trap_lat", 32'(resp_cyc), 32'd1);
        check("trap_mis", 32'(resp_mis), 32'd1);
        check("trap_ld", resp_ld, 32'h0);
        issue(STORE, STORE_HALF, 32'h0001_0003, 32'h0000_1234);
        check("trap_sh_nacc", 32'(nacc), 32'd0);
        check("trap_sh_mis", 32'(resp_mis), 32'd1);
        load_expect("trap_lw_al", LOAD_WORD, 32'h0001_0004, 32'hDEAD_BEEF, 2);
        check("trap_al_mis", 32'(resp_mis), 32'd0);
`else
        issue(STORE, STORE_WORD, 32'h0001_0003, 32'h1122_3344);
        check("ssw_nacc", 32'(nacc), 32'd2);
        check("ssw_lo_addr", acc_addr[0], 32'h0001_0000);
        check("ssw_lo_be", 32'(acc_be[0]), 32'h8);
        check("ssw_lo_dat", acc_dat[0], 32'h4400_0000);
        check("ssw_hi_addr", acc_addr[1], 32'h0001_0004);
        check("ssw_hi_be", 32'(acc_be[1]), 32'h7);
        check("ssw_hi_dat", acc_dat[1], 32'h0011_2233);
        check("ssw_lat", 32'(resp_cyc), 32'd3);
        load_expect("slw", LOAD_WORD, 32'h0001_0003, 32'h1122_3344, 3);
        check("slw_mis", 32'(resp_mis), 32'd0);

        issue(STORE, STORE_WORD, 32'h0001_0000, 32'h8000_0000);
        issue(STORE, STORE_WORD, 32'h0001_0004, 32'h0000_007F);
        load_expect("lh_pos", LOAD_HALF, 32'h0001_0003, 32'h0000_7F80, 3);
        load_expect("lhu_pos", ULOAD_HALF, 32'h0001_0003, 32'h0000_7F80, 3);
        issue(STORE, STORE_BYTE, 32'h0001_0003, 32'h0000_00FF);
        issue(STORE, STORE_BYTE, 32'h0001_0004, 32'h0000_0080);
        load_expect("lh_neg", LOAD_HALF, 32'h0001_0003, 32'hFFFF_80FF, 3);
        load_expect("lhu_neg", ULOAD_HALF, 32'h0001_0003, 32'h0000_80FF, 3);

        // Reset pulse in the HI cycle of a split store.
        @(negedge clk);
        bus.iValid                 = 1'b1;
        bus.iInstructionType       = STORE;
        bus.iMemoryInstructionType = STORE_WORD;
        bus.iAddress               = 32'h0001_0003;
        bus.iWriteData             = 32'hCAFE_F00D;
        @(negedge clk);
        bus.iValid = 1'b0;
        check("rst_mid_lo_en", 32'(bus.oMemEn), 32'd1);
        @(negedge clk);
        check("rst_mid_hi_en", 32'(bus.oMemEn), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", 32'(bus.oBusy), 32'd0);
        check("rst_mid_memen", 32'(bus.oMemEn), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy2", 32'(bus.oBusy), 32'd0);
        load_expect("rst_hi_kept", LOAD_WORD, 32'h0001_0004, 32'h0000_0080, 2);
        load_expect("rst_lo_done", ULOAD_BYTE, 32'h0001_0003, 32'h0000_000D, 2);
`endif

        // Requests offered while busy, or of a non-memory type, are dropped.
        @(negedge clk);
        bus.iValid                 = 1'b1;
        bus.iInstructionType       = LOAD;
        bus.iMemoryInstructionType = LOAD_WORD;
        bus.iAddress               = 32'h0001_0004;
        @(negedge clk);
        check("drop_busy", 32'(bus.oBusy), 32'd1);
        bus.iInstructionType       = STORE;
        bus.iMemoryInstructionType = STORE_WORD;
        bus.iAddress               = 32'h0001_0008;
        bus.iWriteData             = 32'h5555_5555;
        @(negedge clk);
        check("drop_resp", 32'(bus.oRespValid), 32'd1);
        bus.iValid = 1'b0;
        @(negedge clk);
        check("drop_idle", 32'(bus.oBusy), 32'd0);
        check("drop_noacc", 32'(bus.oMemEn), 32'd0);
        check("drop_mem", mem[2], 32'h0);

        bus.iValid           = 1'b1;
        bus.iInstructionType = ALU;
        @(negedge clk);
        bus.iValid = 1'b0;
        check("alu_busy", 32'(bus.oBusy), 32'd0);
        check("alu_memen", 32'(bus.oMemEn), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
